// File: rtl/sha_block_feeder.sv
// sha_block_feeder: packs a stream of 32-bit big-endian message words into
// 512-bit SHA-256 blocks. It applies the standard padding and 64-bit length
// trailer, and hands each block to an external compression core one at a time.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   s_valid/s_ready     input word handshake (s_ready decoded from state only)
//   s_data              message word, byte 0 in [31:24]
//   s_last, s_bytes     final-word flag; valid bytes minus 1 in the final word
//   core_valid          one-cycle block strobe to the core
//   core_mode           1 = INIT (first block of message), 0 = HASH
//   core_message        block; word i at [511-32i -: 32]
//   core_out_valid      core finished the block in flight
//   core_hash           running digest from the core
//   dig_valid, dig_hash final digest pulse and held digest value
//   busy                low only when idle between messages
module sha_block_feeder (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_last,
  input  logic [1:0]   s_bytes,
  output logic         core_valid,
  output logic [1:0]   core_mode,
  output logic [511:0] core_message,
  input  logic         core_out_valid,
  input  logic [255:0] core_hash,
  output logic         dig_valid,
  output logic [255:0] dig_hash,
  output logic         busy
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned NWORDS = 16;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned LEN_W  = 64;
  localparam int unsigned HASH_W = 256;

  typedef enum logic [2:0] {FILL, PAD, ISSUE, WAIT, XPAD, DONE} state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                wcnt_q, wcnt_d;
  logic [LEN_W-1:0]                len_q, len_d;
  logic                            xtra_q, xtra_d;
  logic                            fin_q, fin_d;
  logic                            first_q, first_d;
  logic                            open_q, open_d;
  logic [1:0]                      lbytes_q, lbytes_d;
  logic [CNT_W-1:0]                p_q, p_d;
  logic [0:NWORDS-1][WORD_W-1:0]   buf_q, buf_d;
  logic [HASH_W-1:0]               hcap_q, hcap_d;

  logic [3:0]        w_idx;
  logic [CNT_W-1:0]  p_new;
  logic [WORD_W-1:0] pad_word;

  assign core_message = buf_q;

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    len_d    = len_q;
    xtra_d   = xtra_q;
    fin_d    = fin_q;
    first_d  = first_q;
    open_d   = open_q;
    lbytes_d = lbytes_q;
    p_d      = p_q;
    buf_d    = buf_q;
    hcap_d   = hcap_q;
    w_idx    = 4'(wcnt_q - CNT_W'(1));
    p_new    = (lbytes_q == 2'd3) ? wcnt_q : {1'b0, w_idx};
    pad_word = buf_q[w_idx];

    case (state_q)
      FILL: begin
        if (s_valid) begin
          buf_d[wcnt_q[3:0]] = s_data;
          wcnt_d = wcnt_q + CNT_W'(1);
          open_d = 1'b1;
          if (s_last) begin
            len_d    = len_q + LEN_W'(6'({1'b0, s_bytes, 3'b000}) + 6'd8);
            lbytes_d = s_bytes;
            state_d  = PAD;
          end else begin
            len_d = len_q + LEN_W'(32);
            if (wcnt_q == CNT_W'(NWORDS - 1)) state_d = ISSUE;
          end
        end
      end

      PAD: begin
        // Clear everything past the pad word, then place the 0x80 marker
        for (int i = 0; i < NWORDS; i++) begin
          if (CNT_W'(i) > p_new) buf_d[i] = '0;
        end
        case (lbytes_q)
          2'd0:    pad_word = {buf_q[w_idx][31:24], 8'h80, 16'h0000};
          2'd1:    pad_word = {buf_q[w_idx][31:16], 8'h80, 8'h00};
          2'd2:    pad_word = {buf_q[w_idx][31:8], 8'h80};
          default: pad_word = 32'h8000_0000;
        endcase
        if (lbytes_q != 2'd3) begin
          buf_d[w_idx] = pad_word;
        end else if (p_new < CNT_W'(NWORDS)) begin
          buf_d[p_new[3:0]] = pad_word;
        end
        // Length fits only if words 14/15 are still free
        if (p_new <= CNT_W'(13)) begin
          buf_d[14] = len_q[63:32];
          buf_d[15] = len_q[31:0];
        end else begin
          xtra_d = 1'b1;
        end
        p_d     = p_new;
        fin_d   = 1'b1;
        state_d = ISSUE;
      end

      ISSUE: begin
        first_d = 1'b0;
        state_d = WAIT;
      end

      WAIT: begin
        if (core_out_valid) begin
          hcap_d = core_hash;
          if (fin_q) begin
            state_d = xtra_q ? XPAD : DONE;
          end else begin
            wcnt_d  = '0;
            state_d = FILL;
          end
        end
      end

      XPAD: begin
        // Trailer-only block; carries the marker when the data filled block one
        buf_d = '0;
        if (p_q == CNT_W'(NWORDS)) buf_d[0] = 32'h8000_0000;
        buf_d[14] = len_q[63:32];
        buf_d[15] = len_q[31:0];
        xtra_d    = 1'b0;
        state_d   = ISSUE;
      end

      DONE: begin
        len_d   = '0;
        wcnt_d  = '0;
        first_d = 1'b1;
        fin_d   = 1'b0;
        open_d  = 1'b0;
        state_d = FILL;
      end

      default: state_d = FILL;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FILL;
      wcnt_q     <= '0;
      len_q      <= '0;
      xtra_q     <= 1'b0;
      fin_q      <= 1'b0;
      first_q    <= 1'b1;
      open_q     <= 1'b0;
      lbytes_q   <= '0;
      p_q        <= '0;
      buf_q      <= '0;
      hcap_q     <= '0;
      s_ready    <= 1'b1;
      core_valid <= 1'b0;
      core_mode  <= 2'd0;
      dig_valid  <= 1'b0;
      dig_hash   <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      len_q      <= len_d;
      xtra_q     <= xtra_d;
      fin_q      <= fin_d;
      first_q    <= first_d;
      open_q     <= open_d;
      lbytes_q   <= lbytes_d;
      p_q        <= p_d;
      buf_q      <= buf_d;
      hcap_q     <= hcap_d;
      s_ready    <= (state_d == FILL);
      core_valid <= (state_d == ISSUE);
      core_mode  <= ((state_d == ISSUE) && first_q) ? 2'd1 : 2'd0;
      dig_valid  <= (state_q == DONE);
      if (state_q == DONE) dig_hash <= hcap_q;
      busy       <= !((state_d == FILL) && (wcnt_d == '0) && !open_d);
    end
  end

endmodule

// File: tb/tb_sha_block_feeder.sv
// tb_sha_block_feeder: scoreboard bench for sha_block_feeder with a
// behavioural SHA-256 core model (configurable latency).
module tb_sha_block_feeder;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_last;
  logic [1:0]   s_bytes;
  logic         core_valid;
  logic [1:0]   core_mode;
  logic [511:0] core_message;
  logic         core_out_valid = 1'b0;
  logic [255:0] core_hash = '0;
  logic         dig_valid;
  logic [255:0] dig_hash;
  logic         busy;

  sha_block_feeder dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .s_bytes(s_bytes),
    .core_valid(core_valid), .core_mode(core_mode), .core_message(core_message),
    .core_out_valid(core_out_valid), .core_hash(core_hash),
    .dig_valid(dig_valid), .dig_hash(dig_hash), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_comp(input logic [255:0] hin, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = m[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
             (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  function automatic logic [511:0] putw(input logic [511:0] b, input int i, input logic [31:0] v);
    b[511-32*i -: 32] = v;
    return b;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [511:0] exp_blk[$];
  logic [1:0]   exp_mode[$];
  logic [255:0] exp_dig[$];
  int           ncv = 0;

  // Behavioural core: chains digests, flags overlapping or early blocks
  int           lat = 3;
  int           cnt = 0;
  int           last_cov = -1;
  logic [255:0] core_h = '0;
  logic [255:0] core_res = '0;
  always @(negedge clk) begin
    core_out_valid = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        core_out_valid = 1'b1;
        core_hash      = core_res;
        last_cov       = cyc;
      end
    end
    if (core_valid && !reset) begin
      chk(cnt == 0 && cyc > last_cov, "core_valid_spacing", 512'(cyc), 512'(last_cov));
      core_res = sha_comp((core_mode == 2'd1) ? IV : core_h, core_message);
      core_h   = core_res;
      cnt      = lat;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a block or digest
  always @(negedge clk) begin
    if (!reset) begin
      if (core_valid) begin
        ncv++;
        if (exp_blk.size() == 0) begin
          chk(1'b0, "unexpected_core_valid", 512'(core_message), 512'(0));
        end else begin
          logic [511:0] eb;
          logic [1:0]   em;
          eb = exp_blk.pop_front();
          em = exp_mode.pop_front();
          chk(core_message == eb, "core_message", core_message, eb);
          chk(core_mode == em, "core_mode", 512'(core_mode), 512'(em));
          chk(s_ready == 1'b0, "s_ready_in_issue", 512'(s_ready), 512'(0));
          chk(busy == 1'b1, "busy_in_issue", 512'(busy), 512'(1));
        end
      end
      if (dig_valid) begin
        if (exp_dig.size() == 0) begin
          chk(1'b0, "unexpected_dig_valid", 512'(dig_hash), 512'(0));
        end else begin
          logic [255:0] ed;
          ed = exp_dig.pop_front();
          chk(dig_hash == ed, "dig_hash", 512'(dig_hash), 512'(ed));
        end
      end
    end
  end

  logic [31:0] mw [17];
  int          mn;
  logic [1:0]  mlb;

  // Called at a negedge; returns at the negedge after the word was taken
  task automatic send_word(input logic [31:0] d, input bit last, input logic [1:0] nb);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    s_bytes = nb;
    n = 0;
    while (!s_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk(1'b0, "s_ready_timeout", 512'(n), 512'(2000));
    @(negedge clk);
  endtask

  task automatic send_msg();
    for (int i = 0; i < mn; i++) send_word(mw[i], i == mn - 1, mlb);
  endtask

  task automatic go_idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_blk.size() != 0 || exp_dig.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(n < 5000, "drain_timeout", 512'(exp_blk.size()), 512'(0));
    repeat (4) @(negedge clk);
  endtask

  localparam logic [31:0] BASE [14] = '{
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
    32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};

  localparam logic [255:0] DIG_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_56 =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic [511:0] b1, b2;
  logic [255:0] last_dig;
  int           ncv0, n;

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    s_bytes = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk(s_ready == 1'b1, "reset_s_ready", 512'(s_ready), 512'(1));
    chk(core_valid == 1'b0, "reset_core_valid", 512'(core_valid), 512'(0));
    chk(core_mode == 2'd0, "reset_core_mode", 512'(core_mode), 512'(0));
    chk(dig_valid == 1'b0, "reset_dig_valid", 512'(dig_valid), 512'(0));
    chk(dig_hash == '0, "reset_dig_hash", 512'(dig_hash), 512'(0));
    chk(busy == 1'b0, "reset_busy", 512'(busy), 512'(0));

    // "abc"
    mw[0] = 32'h61626300; mn = 1; mlb = 2'd2;
    b1 = '0; b1 = putw(b1, 0, 32'h61626380); b1 = putw(b1, 15, 32'h18);
    exp_blk.push_back(b1); exp_mode.push_back(2'd1); exp_dig.push_back(DIG_ABC);
    send_msg();

    // 56 bytes: marker fills word 14, length needs an extra block
    for (int i = 0; i < 14; i++) mw[i] = BASE[i];
    mn = 14; mlb = 2'd3;
    b1 = '0;
    for (int i = 0; i < 14; i++) b1 = putw(b1, i, BASE[i]);
    b1 = putw(b1, 14, 32'h80000000);
    b2 = '0; b2 = putw(b2, 15, 32'h1c0);
    exp_blk.push_back(b1); exp_mode.push_back(2'd1);
    exp_blk.push_back(b2); exp_mode.push_back(2'd0);
    exp_dig.push_back(DIG_56);
    send_msg();

    // 64 bytes: pure data block, marker and length in the extra block
    mw[14] = 32'h01020304; mw[15] = 32'h05060708; mn = 16; mlb = 2'd3;
    b1 = '0;
    for (int i = 0; i < 16; i++) b1 = putw(b1, i, mw[i]);
    b2 = '0; b2 = putw(b2, 0, 32'h80000000); b2 = putw(b2, 15, 32'h200);
    exp_blk.push_back(b1); exp_mode.push_back(2'd1);
    exp_blk.push_back(b2); exp_mode.push_back(2'd0);
    exp_dig.push_back(sha_comp(sha_comp(IV, b1), b2));
    send_msg();

    // 60 bytes: marker in word 15, extra block holds only the length
    mn = 15; mlb = 2'd3;
    b1 = '0;
    for (int i = 0; i < 15; i++) b1 = putw(b1, i, mw[i]);
    b1 = putw(b1, 15, 32'h80000000);
    b2 = '0; b2 = putw(b2, 15, 32'h1e0);
    exp_blk.push_back(b1); exp_mode.push_back(2'd1);
    exp_blk.push_back(b2); exp_mode.push_back(2'd0);
    exp_dig.push_back(sha_comp(sha_comp(IV, b1), b2));
    send_msg();

    // "abcd": full final word, marker in the next word
    mw[0] = 32'h61626364; mn = 1; mlb = 2'd3;
    b1 = '0; b1 = putw(b1, 0, 32'h61626364); b1 = putw(b1, 1, 32'h80000000); b1 = putw(b1, 15, 32'h20);
    exp_blk.push_back(b1); exp_mode.push_back(2'd1);
    exp_dig.push_back(sha_comp(IV, b1));
    send_msg();

    // 5 bytes: trailing garbage bytes in the last word must be cleared
    mw[0] = 32'hdeadbeef; mw[1] = 32'h41ffeedd; mn = 2; mlb = 2'd0;
    b1 = '0; b1 = putw(b1, 0, 32'hdeadbeef); b1 = putw(b1, 1, 32'h41800000); b1 = putw(b1, 15, 32'h28);
    exp_blk.push_back(b1); exp_mode.push_back(2'd1);
    exp_dig.push_back(sha_comp(IV, b1));
    send_msg();

    // 66 bytes: second block is a HASH data block with stale words cleared
    for (int i = 0; i < 14; i++) mw[i] = BASE[i];
    mw[14] = 32'h01020304; mw[15] = 32'h05060708; mw[16] = 32'hcafef00d; mn = 17; mlb = 2'd1;
    b1 = '0;
    for (int i = 0; i < 16; i++) b1 = putw(b1, i, mw[i]);
    b2 = '0; b2 = putw(b2, 0, 32'hcafe8000); b2 = putw(b2, 15, 32'h210);
    exp_blk.push_back(b1); exp_mode.push_back(2'd1);
    exp_blk.push_back(b2); exp_mode.push_back(2'd0);
    last_dig = sha_comp(sha_comp(IV, b1), b2);
    exp_dig.push_back(last_dig);
    send_msg();
    go_idle();
    drain();

    chk(dig_hash == last_dig, "dig_hash_held", 512'(dig_hash), 512'(last_dig));
    chk(busy == 1'b0, "idle_busy", 512'(busy), 512'(0));
    chk(s_ready == 1'b1, "idle_s_ready", 512'(s_ready), 512'(1));

    // Reset while the core is working; its late completion must be ignored
    lat = 10;
    ncv0 = ncv;
    mw[0] = 32'h61626300; mn = 1; mlb = 2'd2;
    b1 = '0; b1 = putw(b1, 0, 32'h61626380); b1 = putw(b1, 15, 32'h18);
    exp_blk.push_back(b1); exp_mode.push_back(2'd1);
    send_msg();
    go_idle();
    n = 0;
    while (ncv == ncv0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(n < 200, "abort_issue_timeout", 512'(n), 512'(200));
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk(s_ready == 1'b1, "post_abort_s_ready", 512'(s_ready), 512'(1));
    chk(busy == 1'b0, "post_abort_busy", 512'(busy), 512'(0));
    chk(dig_hash == '0, "post_abort_dig_hash", 512'(dig_hash), 512'(0));

    lat = 3;
    exp_blk.push_back(b1); exp_mode.push_back(2'd1); exp_dig.push_back(DIG_ABC);
    send_msg();
    go_idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
